// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-mask helpers for the AXI-Stream header inserter.
// Helpers take masks zero-extended to MaxBytes lanes so that any stream width can use them.
package axis_hdr_pkg;

   localparam int unsigned MaxBytes = 64;

   typedef enum logic [1:0] {StIdle, StBody, StTail} state_e;

   function automatic int unsigned popcount(input logic [MaxBytes-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MaxBytes; i++) n += 32'(v[i]);
      return n;
   endfunction

   function automatic logic [MaxBytes-1:0] ones_lsb(input int unsigned n);
      logic [MaxBytes-1:0] m;
      for (int unsigned i = 0; i < MaxBytes; i++) m[i] = (i < n);
      return m;
   endfunction

   // True when the set bits form one run starting at bit 0.
   function automatic logic lsb_contig(input logic [MaxBytes-1:0] v);
      return (v & (v + MaxBytes'(1))) == '0;
   endfunction

   // True when the set bits form one run ending at bit n-1.
   function automatic logic msb_contig(input logic [MaxBytes-1:0] v, input int unsigned n);
      logic [MaxBytes-1:0] inv;
      inv = ~v & ones_lsb(n);
      return lsb_contig(inv);
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream output holding register; payload holds while stalled.
module axis_reg_slice #(
   parameter int unsigned DATA_WD = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_WD-1:0]   in_data,
   input  logic [DATA_WD/8-1:0] in_keep,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [DATA_WD-1:0]   out_data,
   output logic [DATA_WD/8-1:0] out_keep,
   output logic                 out_last,
   input  logic                 out_ready
);

   assign in_ready = ~out_valid | out_ready;

   // Drained payload is cleared so idle outputs read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_keep  <= in_keep;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_header_inserter.sv
// Prepends a 1..N byte header to an AXI-Stream packet, realigning the body bytes behind it.
// Bytes of the previous beat not yet emitted are held as a residue and shifted in front.
module axis_header_inserter
   import axis_hdr_pkg::*;
#(
   parameter int unsigned DATA_WD      = 32,
   parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
   parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
   output logic                    ready_insert,
   output logic                    err_keep
);

   localparam int unsigned NB  = DATA_BYTE_WD;
   localparam int unsigned HWd = $clog2(DATA_BYTE_WD + 1);

   function automatic logic [NB-1:0] keep_msb(input int unsigned n);
      logic [MaxBytes-1:0] m;
      m = ~ones_lsb(NB - n);
      return m[NB-1:0];
   endfunction

   state_e             state_q, state_d;
   logic [HWd-1:0]     h_q, tail_cnt_q;
   logic [DATA_WD-1:0] res_q, data_m;
   logic               alive_q, err_q, err_d;
   logic               hdr_hs, in_hs, fits;
   int unsigned        h_ins, k_in, h_cur, room;

   logic               s_valid, s_ready, s_last;
   logic [DATA_WD-1:0] s_data;
   logic [NB-1:0]      s_keep;

   // Header length comes from keep_insert; the count input carries no extra information.
   logic unused_cnt;
   assign unused_cnt = ^byte_insert_cnt;

   assign hdr_hs   = valid_insert & ready_insert;
   assign in_hs    = valid_in & ready_in;
   assign err_keep = err_q;

   always_comb begin
      h_ins  = popcount(MaxBytes'(keep_insert));
      k_in   = popcount(MaxBytes'(keep_in));
      h_cur  = 32'(h_q);
      room   = NB - h_cur;
      fits   = k_in <= room;
      data_m = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         data_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
      end
   end

   always_comb begin
      err_d = 1'b0;
      if (hdr_hs && (keep_insert == '0 || !lsb_contig(MaxBytes'(keep_insert)))) err_d = 1'b1;
      if (in_hs && (keep_in == '0 || !msb_contig(MaxBytes'(keep_in), NB))) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (hdr_hs) state_d = StBody;
         StBody:  if (in_hs && last_in) state_d = fits ? StIdle : StTail;
         StTail:  if (s_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready_insert = 1'b0;
      ready_in     = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      s_keep       = '0;
      s_last       = 1'b0;
      unique case (state_q)
         StIdle: ready_insert = alive_q & s_ready;
         StBody: begin
            ready_in = s_ready;
            s_valid  = valid_in;
            s_data   = (res_q << (8 * room)) | (data_m >> (8 * h_cur));
            if (last_in && fits) begin
               s_keep = keep_msb(h_cur + k_in);
               s_last = 1'b1;
            end else begin
               s_keep = '1;
            end
         end
         StTail: begin
            s_valid = 1'b1;
            s_data  = res_q << (8 * room);
            s_keep  = keep_msb(32'(tail_cnt_q));
            s_last  = 1'b1;
         end
         default: ;
      endcase
   end

   // alive_q holds ready_insert low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q        <= '0;
         tail_cnt_q <= '0;
         res_q      <= '0;
         alive_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         err_q   <= err_d;
         if (hdr_hs) begin
            h_q   <= HWd'(h_ins);
            res_q <= data_insert;
         end else if (in_hs) begin
            res_q      <= data_m;
            tail_cnt_q <= fits ? '0 : HWd'(k_in - room);
         end
      end
   end

   axis_reg_slice #(
      .DATA_WD(DATA_WD)
   ) u_out_slice (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_valid),
      .in_data   (s_data),
      .in_keep   (s_keep),
      .in_last   (s_last),
      .in_ready  (s_ready),
      .out_valid (valid_out),
      .out_data  (data_out),
      .out_keep  (keep_out),
      .out_last  (last_out),
      .out_ready (ready_out)
   );

endmodule

// File: tb/tb_axis_header_inserter.sv
// Bench for axis_header_inserter: byte-stream reference model, per-cycle output checker and
// directed packets with literal expected beats.
module tb_axis_header_inserter;

   localparam int unsigned DW = 32;
   localparam int unsigned NB = 4;
   localparam int unsigned CW = 2;

   logic          clk;
   logic          rst;
   logic          valid_in, last_in, ready_in;
   logic [DW-1:0] data_in;
   logic [NB-1:0] keep_in;
   logic          valid_out, last_out, ready_out;
   logic [DW-1:0] data_out;
   logic [NB-1:0] keep_out;
   logic          valid_insert, ready_insert, err_keep;
   logic [DW-1:0] data_insert;
   logic [NB-1:0] keep_insert;
   logic [CW-1:0] byte_insert_cnt;

   axis_header_inserter #(
      .DATA_WD      (DW),
      .DATA_BYTE_WD (NB),
      .BYTE_CNT_WD  (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out),
      .valid_insert    (valid_insert),
      .data_insert     (data_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .ready_insert    (ready_insert),
      .err_keep        (err_keep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       log_q[$];
   int          tests = 0;
   int          fails = 0;
   int          err_cnt, err_max, err_run;
   int          rdy_mode;
   logic [31:0] bd[8];
   logic [3:0]  bk[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Reference: header bytes then valid body bytes, MSB lane first, repacked into N-byte beats.
   task automatic model_packet(input logic [3:0] hk, input logic [31:0] hd, input int nb);
      logic [7:0] q[$];
      beat_t      b;
      int         h;
      h = $countones(hk);
      for (int i = h - 1; i >= 0; i--) q.push_back(hd[8*i +: 8]);
      for (int j = 0; j < nb; j++)
         for (int l = NB - 1; l >= 0; l--)
            if (bk[j][l]) q.push_back(bd[j][8*l +: 8]);
      while (q.size() > 0) begin
         b = '0;
         for (int l = NB - 1; l >= 0 && q.size() > 0; l--) begin
            b.data[8*l +: 8] = q.pop_front();
            b.keep[l]        = 1'b1;
         end
         b.last = (q.size() == 0);
         exp_q.push_back(b);
      end
   endtask

   task automatic monitor();
      logic        stall;
      beat_t       prev, e, got;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall   = 1'b0;
            err_run = 0;
            continue;
         end
         if (stall) begin
            check("hold_valid", 32'(valid_out), 32'd1);
            check("hold_data", data_out, prev.data);
            check("hold_keep", 32'(keep_out), 32'(prev.keep));
            check("hold_last", 32'(last_out), 32'(prev.last));
         end
         if (valid_out && !ready_out) check("stall_ready_in", 32'(ready_in), 32'd0);
         if (valid_out && ready_out) begin
            got.data = data_out;
            got.keep = keep_out;
            got.last = last_out;
            log_q.push_back(got);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got 0x%08h, required no beat", data_out);
            end else begin
               e = exp_q.pop_front();
               check("out_data", data_out, e.data);
               check("out_keep", 32'(keep_out), 32'(e.keep));
               check("out_last", 32'(last_out), 32'(e.last));
            end
         end
         stall     = valid_out && !ready_out;
         prev.data = data_out;
         prev.keep = keep_out;
         prev.last = last_out;
         if (err_keep) begin
            err_cnt++;
            err_run++;
            if (err_run > err_max) err_max = err_run;
         end else begin
            err_run = 0;
         end
      end
   endtask

   task automatic rdy_drv();
      forever begin
         @(posedge clk);
         #1 ready_out = (rdy_mode == 0) ? 1'b1 : ~ready_out;
      end
   endtask

   task automatic send_header(input logic [3:0] hk, input logic [31:0] hd);
      int n;
      @(posedge clk);
      #1;
      valid_insert    = 1'b1;
      data_insert     = hd;
      keep_insert     = hk;
      byte_insert_cnt = CW'($countones(hk) % NB);
      n = 0;
      @(negedge clk);
      while (!ready_insert && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_insert) begin
         tests++;
         fails++;
         $display("FAIL header_timeout: got ready_insert=0, required 1");
      end
      @(posedge clk);
      #1 valid_insert = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      n = 0;
      @(negedge clk);
      while (!ready_in && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_in) begin
         tests++;
         fails++;
         $display("FAIL beat_timeout: got ready_in=0, required 1");
      end
      @(posedge clk);
      #1;
      if (rdy_mode == 0) check("latency_valid", 32'(valid_out), 32'd1);
   endtask

   task automatic send_packet(input logic [3:0] hk, input logic [31:0] hd, input int nb);
      model_packet(hk, hd, nb);
      send_header(hk, hd);
      for (int j = 0; j < nb; j++) send_beat(bd[j], bk[j], j == nb - 1);
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_log(input int idx, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
      if (idx >= log_q.size()) begin
         tests++;
         fails++;
         $display("FAIL beat%0d_missing: got no beat, required 0x%08h", idx, d);
      end else begin
         check($sformatf("beat%0d_data", idx), log_q[idx].data, d);
         check($sformatf("beat%0d_keep", idx), 32'(log_q[idx].keep), 32'(k));
         check($sformatf("beat%0d_last", idx), 32'(log_q[idx].last), 32'(l));
      end
   endtask

   task automatic start_case();
      log_q.delete();
      err_cnt = 0;
      err_max = 0;
   endtask

   task automatic load_req027();
      bd[0] = 32'h11223344; bk[0] = 4'b1111;
      bd[1] = 32'h55667788; bk[1] = 4'b1111;
   endtask

   initial begin
      rst = 1'b1;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
      ready_out = 1'b1;
      rdy_mode  = 0;
      err_cnt = 0; err_max = 0; err_run = 0;
      fork
         monitor();
         rdy_drv();
         begin
            #200000;
            $display("FAIL global_timeout: got no finish, required finish");
            $fatal(1, "timeout");
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_ready_in", 32'(ready_in), 32'd0);
      check("rst_ready_insert", 32'(ready_insert), 32'd0);
      check("rst_err_keep", 32'(err_keep), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check("ready_insert_up", 32'(ready_insert), 32'd1);

      // H=3 across two full beats, needs a tail beat
      start_case();
      load_req027();
      send_packet(4'b0111, 32'h00AABBCC, 2);
      drain();
      check_log(0, 32'hAABBCC11, 4'b1111, 1'b0);
      check_log(1, 32'h22334455, 4'b1111, 1'b0);
      check_log(2, 32'h66778800, 4'b1110, 1'b1);
      check("h3_err_count", 32'(err_cnt), 32'd0);

      // H=N: header alone as first beat
      start_case();
      bd[0] = 32'h01020304; bk[0] = 4'b1100;
      send_packet(4'b1111, 32'hDEADBEEF, 1);
      drain();
      check_log(0, 32'hDEADBEEF, 4'b1111, 1'b0);
      check_log(1, 32'h01020000, 4'b1100, 1'b1);

      // H=1, short last beat fits: no tail
      start_case();
      bd[0] = 32'h11223344; bk[0] = 4'b1110;
      send_packet(4'b0001, 32'h000000EE, 1);
      drain();
      check_log(0, 32'hEE112233, 4'b1111, 1'b1);
      check("h1_beats", 32'(log_q.size()), 32'd1);

      // Same as the H=3 case with ready_out toggling
      start_case();
      rdy_mode = 1;
      load_req027();
      send_packet(4'b0111, 32'h00AABBCC, 2);
      drain();
      rdy_mode = 0;
      check_log(0, 32'hAABBCC11, 4'b1111, 1'b0);
      check_log(1, 32'h22334455, 4'b1111, 1'b0);
      check_log(2, 32'h66778800, 4'b1110, 1'b1);

      // Non-contiguous header keep: one error pulse, H=2
      start_case();
      bd[0] = 32'hA1B2C3D4; bk[0] = 4'b1111;
      send_packet(4'b0101, 32'h44332211, 1);
      drain();
      check_log(0, 32'h2211A1B2, 4'b1111, 1'b0);
      check_log(1, 32'hC3D40000, 4'b1100, 1'b1);
      check("err_pulse_count", 32'(err_cnt), 32'd1);
      check("err_pulse_width", 32'(err_max), 32'd1);

      // Back-to-back packets checked against the model only
      start_case();
      bd[0] = 32'hA0A1A2A3; bk[0] = 4'b1111;
      bd[1] = 32'hB0B1B2B3; bk[1] = 4'b1111;
      bd[2] = 32'hC0000000; bk[2] = 4'b1000;
      send_packet(4'b0011, 32'h0000CAFE, 3);
      bd[0] = 32'h89ABCDEF; bk[0] = 4'b1111;
      bd[1] = 32'h13579BDF; bk[1] = 4'b1111;
      send_packet(4'b1111, 32'h01234567, 2);
      drain();
      check_log(2, 32'hB2B3C000, 4'b1110, 1'b1);
      check("b2b_beats", 32'(log_q.size()), 32'd6);

      // Reset during the second body beat
      start_case();
      load_req027();
      model_packet(4'b0111, 32'h00AABBCC, 2);
      send_header(4'b0111, 32'h00AABBCC);
      send_beat(bd[0], bk[0], 1'b0);
      valid_in = 1'b1; data_in = bd[1]; keep_in = bk[1]; last_in = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      check("mid_rst_valid_out", 32'(valid_out), 32'd0);
      check("mid_rst_last_out", 32'(last_out), 32'd0);
      check("mid_rst_ready_in", 32'(ready_in), 32'd0);
      check("mid_rst_ready_insert", 32'(ready_insert), 32'd0);
      check("mid_rst_err_keep", 32'(err_keep), 32'd0);
      check("mid_rst_data_out", data_out, 32'd0);
      check("mid_rst_keep_out", 32'(keep_out), 32'd0);
      valid_in = 1'b0; last_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("rel_ready_insert_low", 32'(ready_insert), 32'd0);
      @(posedge clk);
      #1 check("rel_ready_insert_high", 32'(ready_insert), 32'd1);
      start_case();
      bd[0] = 32'h11223344; bk[0] = 4'b1110;
      send_packet(4'b0001, 32'h000000EE, 1);
      drain();
      check_log(0, 32'hEE112233, 4'b1111, 1'b1);
      check("post_rst_beats", 32'(log_q.size()), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axis_header_inserter.md
AXIS_HEADER_INSERTER -- requirements
Module: axis_header_inserter

Interface
REQ-001 Parameter DATA_WD, default 32: stream data width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8: byte lanes per beat (N).
REQ-003 Parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD): width of byte_insert_cnt.
REQ-004 Port clk, input, 1: single clock, all logic on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Input stream ports: valid_in (in, 1); data_in (in, DATA_WD); keep_in (in, DATA_BYTE_WD); last_in (in, 1); ready_in (out, 1).
REQ-007 Output stream ports: valid_out (out, 1); data_out (out, DATA_WD); keep_out (out, DATA_BYTE_WD); last_out (out, 1); ready_out (in, 1).
REQ-008 Header ports: valid_insert (in, 1); data_insert (in, DATA_WD); keep_insert (in, DATA_BYTE_WD); byte_insert_cnt (in, BYTE_CNT_WD); ready_insert (out, 1).
REQ-009 Port err_keep, output, 1: one-cycle pulse on an illegal keep pattern.

Function
REQ-010 Byte order: lane N-1 (data[DATA_WD-1 -: 8]) is first on the wire; a valid keep is contiguous ones from the MSB end (input) or from the LSB end (header).
REQ-011 Header length H = popcount(keep_insert), 1..N; header bytes are the H least-significant lanes of data_insert; byte_insert_cnt equals H mod N and is informational only.
REQ-012 FSM states: IDLE, BODY, TAIL; reset state IDLE.
REQ-013 IDLE: ready_insert=1 while the output register is empty or draining; header handshake latches H and data_insert, then BODY; ready_in=0.
REQ-014 BODY: ready_in = ~tail_pending & (~valid_out | ready_out); each accepted beat emits {residue H bytes, upper N-H bytes of data_in}; the lower H bytes of data_in become the new residue.
REQ-015 Last beat with K valid bytes: if K <= N-H, emit a single beat with keep = H+K ones from MSB and last_out=1, then IDLE; otherwise emit a full beat, then TAIL.
REQ-016 TAIL: ready_in=0; emit the residue beat with keep = K-(N-H) ones from MSB and last_out=1, then IDLE.
REQ-017 H=N: header is emitted as a full first beat; input beats then pass unshifted, one beat delayed.
REQ-018 Latency: an output beat is valid on the cycle after the accepting input handshake; sustained throughput is 1 beat/cycle with ready_out=1.
REQ-019 AXI rule: once valid_out=1, data_out, keep_out and last_out SHALL hold until ready_out=1; no beat is dropped or duplicated under any ready_out pattern.
REQ-020 Invalid bytes of data_out SHALL be driven to 0.
REQ-021 A non-contiguous keep_insert or keep_in, or keep_in=0, SHALL pulse err_keep; processing continues using popcount.
REQ-022 At most one idle cycle is allowed between packets; valid_insert during BODY or TAIL is not accepted.

Reset
REQ-023 Asserting rst SHALL immediately force valid_out, last_out, ready_in, ready_insert and err_keep to 0, data_out and keep_out to 0, and the FSM to IDLE.
REQ-024 Reset mid-packet SHALL discard the partial packet; ready_insert rises on the first clock edge after rst deasserts.

Structure
REQ-025 Shared package axis_hdr_pkg SHALL hold the FSM state enum and the popcount and contiguity-check functions.
REQ-026 The output holding register SHALL be a separate sub-module, axis_reg_slice, parametrised by DATA_WD.

Verification (DATA_WD=32)
REQ-027 H=3 (keep_insert 0111, data_insert 0x00AABBCC); input 0x11223344, then 0x55667788 keep 1111 last -> output 0xAABBCC11, 0x22334455, 0x66778800 keep 1110 last.
REQ-028 H=4 (header 0xDEADBEEF); input 0x01020304 keep 1100 last -> output 0xDEADBEEF keep 1111, then 0x01020000 keep 1100 last.
REQ-029 H=1 (keep_insert 0001, data_insert 0x000000EE); input 0x11223344 keep 1110 last -> single beat 0xEE112233 keep 1111 last, no TAIL.
REQ-030 Repeat REQ-027 with ready_out toggling 1,0,1,0 -> identical beats; outputs stable while stalled; ready_in=0 when stalled with valid_out=1.
REQ-031 Assert rst during the second beat of REQ-027 -> all outputs 0 at once; after release, ready_insert=1 on the next edge and a fresh packet passes correctly.
REQ-032 keep_insert 0101 -> err_keep pulses exactly one cycle; H=2 is used.
